// File: rtl/rv_pipe_pkg.sv
// Shared pipeline widths, control bit map and ID/EX bundle.
// Imported by every stage of the integer pipe.
package rv_pipe_pkg;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 32;

  localparam int CTRL_USE_RS1   = 7;
  localparam int CTRL_USE_RS2   = 6;
  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_ALU_OP_HI = 1;
  localparam int CTRL_ALU_OP_LO = 0;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand select: x0 zero, EX/MEM, MEM/WB, then
// register file data, in that priority.
module fwd_mux
  import rv_pipe_pkg::*;
(
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  // Register file does not hardwire x0, so zero is forced here.
  always_comb begin
    operand = rs_data;
    if (addr == 5'd0)
      operand = '0;
    else if (exm_reg_write && exm_rd == addr)
      operand = exm_result;
    else if (wb_wen && wb_rd == addr)
      operand = wb_data;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX stage: operand fetch, forwarding, load-use bubble,
// stall/flush handling and bubble counter.
module operand_fetch_stage
  import rv_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [4:0]        Rs1_addr,
  output logic [4:0]        Rs2_addr,
  input  logic [XLEN-1:0]   Rs1_data,
  input  logic [XLEN-1:0]   Rs2_data,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]  op1, op2;
  logic             hazard;
  logic             hit1, hit2;

  assign Rs1_addr = id_rs1_addr;
  assign Rs2_addr = id_rs2_addr;

  fwd_mux u_fwd_rs1 (
    .addr          (id_rs1_addr),
    .rs_data       (Rs1_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_wen        (wb_wen),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .operand       (op1)
  );

  fwd_mux u_fwd_rs2 (
    .addr          (id_rs2_addr),
    .rs_data       (Rs2_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_wen        (wb_wen),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .operand       (op2)
  );

  always_comb begin
    hit1   = id_ctrl[CTRL_USE_RS1] && ex_q.rd == id_rs1_addr;
    hit2   = id_ctrl[CTRL_USE_RS2] && ex_q.rd == id_rs2_addr;
    hazard = ex_q.valid && ex_q.ctrl[CTRL_MEM_READ]
             && ex_q.rd != 5'd0 && (hit1 || hit2);
  end

  assign id_ready = ex_ready & ~hazard & ~flush;

  // Flush beats both a stall and a load-use bubble.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (!ex_ready) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d.valid = 1'b0;
      if (id_valid)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rs1_data = op1;
      ex_d.rs2_data = op2;
      ex_d.imm      = id_imm;
      ex_d.pc       = id_pc;
      ex_d.rd       = id_rd_addr;
      ex_d.ctrl     = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_rd       = ex_q.rd;
  assign ex_ctrl     = ex_q.ctrl;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, forwarding,
// load-use bubble, stall hold, flush priority, counter wrap.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [63:0] id_imm, id_pc;
  logic [7:0]  id_ctrl;
  logic [4:0]  Rs1_addr, Rs2_addr;
  logic [63:0] Rs1_data, Rs2_data;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [63:0] exm_result;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush, ex_ready, ex_valid;
  logic [63:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] C_RS1 = 8'h80;
  localparam logic [7:0] C_RS2 = 8'h40;
  localparam logic [7:0] C_LD  = 8'h20;
  localparam logic [7:0] C_WR  = 8'h08;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_pc(id_pc),
    .id_ctrl(id_ctrl),
    .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
    .Rs1_data(Rs1_data), .Rs2_data(Rs2_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rd_addr = 0; id_imm = 0; id_pc = 0; id_ctrl = 0;
    Rs1_data = 0; Rs2_data = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rs1_addr = 5'd1; id_rd_addr = rd;
    id_ctrl = C_RS1 | C_LD | C_WR; id_pc = 64'h200;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1; idle();
    id_valid = 1; id_rs1_addr = 5'd3; Rs1_data = 64'h55;
    id_rd_addr = 5'd4; id_pc = 64'h40; id_ctrl = C_RS1 | C_WR;
    step();
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (ex_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %0b want 0", ex_valid);
    end
    n_cmp++;
    if ({ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rd, ex_ctrl} !== '0) begin
      n_bad++; $display("FAIL reset_payload got %0h/%0h want 0", ex_rs1_data, ex_pc);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_cnt got %0h want 0", stall_cnt);
    end
    n_cmp++;
    if (id_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %0b want 1", id_ready);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    step();
  endtask

  task automatic test_forward();
    idle();
    id_valid = 1; id_rs1_addr = 5'd5; Rs1_data = 64'h10;
    id_rs2_addr = 5'd6; Rs2_data = 64'h66;
    id_rd_addr = 5'd3; id_pc = 64'h100; id_imm = 64'h4;
    id_ctrl = C_RS1 | C_RS2 | C_WR;
    exm_reg_write = 1; exm_rd = 5'd5; exm_result = 64'hAA;
    wb_wen = 1; wb_rd = 5'd5; wb_data = 64'hBB;
    #1;
    n_cmp++;
    if (Rs1_addr !== 5'd5 || Rs2_addr !== 5'd6) begin
      n_bad++; $display("FAIL rf_addr got %0d/%0d want 5/6", Rs1_addr, Rs2_addr);
    end
    step();
    n_cmp++;
    if (ex_rs1_data !== 64'hAA || ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL fwd_exm got %0h v%0b want aa v1", ex_rs1_data, ex_valid);
    end
    n_cmp++;
    if (ex_rs2_data !== 64'h66 || ex_rd !== 5'd3 || ex_pc !== 64'h100
        || ex_imm !== 64'h4) begin
      n_bad++; $display("FAIL fwd_plain got %0h rd%0d pc%0h want 66 rd3 pc100",
                        ex_rs2_data, ex_rd, ex_pc);
    end
    exm_reg_write = 0;
    step();
    n_cmp++;
    if (ex_rs1_data !== 64'hBB) begin
      n_bad++; $display("FAIL fwd_wb got %0h want bb", ex_rs1_data);
    end
    id_rs1_addr = 5'd0; exm_reg_write = 1; exm_rd = 5'd0;
    wb_rd = 5'd0;
    step();
    n_cmp++;
    if (ex_rs1_data !== 64'h0) begin
      n_bad++; $display("FAIL fwd_x0 got %0h want 0", ex_rs1_data);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    issue_load(5'd7);
    id_valid = 1; id_rs1_addr = 5'd2; Rs1_data = 64'h22;
    id_rs2_addr = 5'd7; Rs2_data = 64'h77; id_rd_addr = 5'd9;
    id_ctrl = C_RS1 | C_RS2 | C_WR; id_pc = 64'h204;
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin
      n_bad++; $display("FAIL lu_ready got %0b want 0", id_ready);
    end
    step();
    n_cmp++;
    if (ex_valid !== 1'b0 || stall_cnt !== 32'd1) begin
      n_bad++; $display("FAIL lu_bubble got v%0b cnt%0d want v0 cnt1", ex_valid, stall_cnt);
    end
    exm_reg_write = 0; exm_rd = 5'd7; exm_result = 64'h200;
    wb_wen = 1; wb_rd = 5'd7; wb_data = 64'h1234;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_ready2 got %0b want 1", id_ready);
    end
    step();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rs2_data !== 64'h1234 || ex_rd !== 5'd9) begin
      n_bad++; $display("FAIL lu_accept got v%0b %0h rd%0d want v1 1234 rd9",
                        ex_valid, ex_rs2_data, ex_rd);
    end
    n_cmp++;
    if (stall_cnt !== 32'd1) begin
      n_bad++; $display("FAIL lu_cnt got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_stall();
    idle();
    ex_ready = 0; id_valid = 1; id_rs1_addr = 5'd11;
    Rs1_data = 64'hF00D; id_rd_addr = 5'd12; id_pc = 64'h300;
    id_ctrl = C_RS1 | C_WR;
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_ready got %0b want 0", id_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_rs2_data !== 64'h1234
          || ex_pc !== 64'h204 || stall_cnt !== 32'd1) begin
        n_bad++; $display("FAIL stall_hold%0d got v%0b rd%0d pc%0h cnt%0d want v1 rd9 pc204 cnt1",
                          i, ex_valid, ex_rd, ex_pc, stall_cnt);
      end
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    issue_load(5'd7);
    id_valid = 1; id_rs1_addr = 5'd7; id_rd_addr = 5'd8;
    id_ctrl = C_RS1 | C_WR; ex_ready = 0; flush = 1;
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready got %0b want 0", id_ready);
    end
    step();
    n_cmp++;
    if (ex_valid !== 1'b0 || stall_cnt !== 32'd1) begin
      n_bad++; $display("FAIL flush_kill got v%0b cnt%0d want v0 cnt1", ex_valid, stall_cnt);
    end
    idle();
  endtask

  task automatic test_wrap();
    issue_load(5'd7);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    #1;
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_preload got %0h want ffffffff", stall_cnt);
    end
    id_valid = 1; id_rs2_addr = 5'd7; id_rd_addr = 5'd10;
    id_ctrl = C_RS2 | C_WR;
    step();
    n_cmp++;
    if (stall_cnt !== 32'd0 || ex_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap got %0h v%0b want 0 v0", stall_cnt, ex_valid);
    end
    idle();
    step();
  endtask

  initial begin
    rst_n = 0;
    idle();
    #12 rst_n = 1;
    test_reset();
    test_forward();
    test_load_use();
    test_stall();
    test_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
